// File: rtl/cmd_bus_master.sv
// Single-outstanding command-bus master: routes host register accesses to one of
// 2**HOST_ADDR_BITS_FOR_SEL slave channels. Optional slave-ack timeout via CMD_MASTER_TIMEOUT_EN.
module cmd_bus_master #(
  parameter int HOST_ADDR_BITS         = 32,
  parameter int HOST_ADDR_BITS_FOR_SEL = 1,
  parameter int HOST_DATA_BITS         = 32,
  parameter int TIMEOUT_CYCLES         = 256
) (
  input  logic                                                 tb_cmd_clk,
  input  logic                                                 tb_cmd_srst,
  input  logic                                                 i_host_sel,
  input  logic                                                 i_host_rd_wr_n,
  input  logic [HOST_ADDR_BITS-1:0]                            i_host_byte_addr,
  input  logic [HOST_DATA_BITS-1:0]                            i_host_wdata,
  output logic                                                 o_host_ack,
  output logic [HOST_DATA_BITS-1:0]                            o_host_rdata,
  output logic [(2**HOST_ADDR_BITS_FOR_SEL)-1:0]               o_cmd_sel,
  output logic                                                 o_cmd_rd_wr_n,
  output logic [HOST_ADDR_BITS-HOST_ADDR_BITS_FOR_SEL-1:0]     o_cmd_addr,
  output logic [HOST_DATA_BITS-1:0]                            o_cmd_wdata,
  input  logic [(2**HOST_ADDR_BITS_FOR_SEL)-1:0]               i_cmd_ack,
  input  logic [(2**HOST_ADDR_BITS_FOR_SEL)*HOST_DATA_BITS-1:0] i_cmd_rdata,
  output logic                                                 o_cmd_err
);

  localparam int NUM_SLAVES    = 2**HOST_ADDR_BITS_FOR_SEL;
  localparam int SEL_W         = HOST_ADDR_BITS_FOR_SEL;
  localparam int CMD_ADDR_BITS = HOST_ADDR_BITS - HOST_ADDR_BITS_FOR_SEL;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                     r_state;
  state_t                     w_next_state;
  logic [SEL_W-1:0]           r_idx;
  logic                       r_rd_wr_n;
  logic [CMD_ADDR_BITS-1:0]   r_addr;
  logic [HOST_DATA_BITS-1:0]  r_wdata;
  logic [HOST_DATA_BITS-1:0]  r_host_rdata;
  logic [HOST_DATA_BITS-1:0]  w_slave_rdata [NUM_SLAVES];
  logic                       w_sel_ack;
  logic                       w_load;
  logic                       w_capture;
  logic                       w_timeout;

  for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_rdata_split
    assign w_slave_rdata[k] = i_cmd_rdata[k*HOST_DATA_BITS +: HOST_DATA_BITS];
  end

  // Only the addressed slave's ack can complete a transaction.
  assign w_sel_ack = i_cmd_ack[r_idx];

`ifdef CMD_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [HOST_DATA_BITS+31:0] DEAD_EXT = {{HOST_DATA_BITS{1'b0}}, 32'hDEAD_BEEF};

  logic [TMO_W-1:0]          r_tmo_cnt;
  logic                      r_err;
  logic [HOST_DATA_BITS-1:0] w_dead;

  assign w_dead    = DEAD_EXT[HOST_DATA_BITS-1:0];
  assign w_timeout = (r_state == WAIT) && !w_sel_ack &&
                     (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign o_cmd_err = r_err;

  always_ff @(posedge tb_cmd_clk or negedge tb_cmd_srst) begin
    if (!tb_cmd_srst) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (r_state == WAIT) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      else                 r_tmo_cnt <= '0;
      if (w_timeout)       r_err     <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign o_cmd_err = 1'b0;
`endif

  always_ff @(posedge tb_cmd_clk or negedge tb_cmd_srst) begin
    if (!tb_cmd_srst) r_state <= IDLE;
    else              r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_host_sel) begin
          w_load       = 1'b1;
          w_next_state = REQ;
        end
      end
      REQ: begin
        if (w_sel_ack) begin
          w_capture    = 1'b1;
          w_next_state = DONE;
        end else begin
          w_next_state = WAIT;
        end
      end
      WAIT: begin
        if (w_sel_ack) begin
          w_capture    = 1'b1;
          w_next_state = DONE;
        end else if (w_timeout) begin
          w_next_state = DONE;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Request fields are latched once in IDLE and held until the next request.
  always_ff @(posedge tb_cmd_clk or negedge tb_cmd_srst) begin
    if (!tb_cmd_srst) begin
      r_idx        <= '0;
      r_rd_wr_n    <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_host_rdata <= '0;
    end else begin
      if (w_load) begin
        r_idx     <= i_host_byte_addr[HOST_ADDR_BITS-1 -: SEL_W];
        r_rd_wr_n <= i_host_rd_wr_n;
        r_addr    <= i_host_byte_addr[CMD_ADDR_BITS-1:0];
        r_wdata   <= i_host_wdata;
      end
      if (w_capture && r_rd_wr_n) begin
        r_host_rdata <= w_slave_rdata[r_idx];
      end
`ifdef CMD_MASTER_TIMEOUT_EN
      if (w_timeout) begin
        r_host_rdata <= w_dead;
      end
`endif
    end
  end

  assign o_host_ack    = (r_state == DONE);
  assign o_host_rdata  = r_host_rdata;
  assign o_cmd_sel     = (r_state == REQ) ? (NUM_SLAVES'(1) << r_idx) : '0;
  assign o_cmd_rd_wr_n = r_rd_wr_n;
  assign o_cmd_addr    = r_addr;
  assign o_cmd_wdata   = r_wdata;

endmodule

// File: tb/tb_cmd_bus_master.sv
// Self-checking bench for cmd_bus_master: two register-slave models acking one cycle
// after sel, a scoreboard of expected slave commands and host completions.
module tb_cmd_bus_master;

  logic        tb_cmd_clk = 1'b0;
  logic        tb_cmd_srst = 1'b0;
  logic        i_host_sel = 1'b0;
  logic        i_host_rd_wr_n = 1'b0;
  logic [31:0] i_host_byte_addr = '0;
  logic [31:0] i_host_wdata = '0;
  logic        o_host_ack;
  logic [31:0] o_host_rdata;
  logic [1:0]  o_cmd_sel;
  logic        o_cmd_rd_wr_n;
  logic [30:0] o_cmd_addr;
  logic [31:0] o_cmd_wdata;
  logic [1:0]  i_cmd_ack;
  logic [63:0] i_cmd_rdata;
  logic        o_cmd_err;

  always #5 tb_cmd_clk = ~tb_cmd_clk;

  cmd_bus_master dut (
    .tb_cmd_clk       (tb_cmd_clk),
    .tb_cmd_srst      (tb_cmd_srst),
    .i_host_sel       (i_host_sel),
    .i_host_rd_wr_n   (i_host_rd_wr_n),
    .i_host_byte_addr (i_host_byte_addr),
    .i_host_wdata     (i_host_wdata),
    .o_host_ack       (o_host_ack),
    .o_host_rdata     (o_host_rdata),
    .o_cmd_sel        (o_cmd_sel),
    .o_cmd_rd_wr_n    (o_cmd_rd_wr_n),
    .o_cmd_addr       (o_cmd_addr),
    .o_cmd_wdata      (o_cmd_wdata),
    .i_cmd_ack        (i_cmd_ack),
    .i_cmd_rdata      (i_cmd_rdata),
    .o_cmd_err        (o_cmd_err)
  );

  typedef struct {
    logic        rdWrN;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  expSel;
    logic [30:0] expCmdAddr;
    logic [31:0] expRdata;
  } vec_t;

  typedef struct {
    logic [1:0]  sel;
    logic        rdWrN;
    logic [30:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } ack_t;

  cmd_t cmdQ[$];
  ack_t ackQ[$];
  cmd_t monCmd;
  ack_t monAck;
  vec_t vecs[9];

  int   compared = 0;
  int   mismatched = 0;
  int   hostAckCount = 0;
  int   ackBefore;
  logic errExpected = 1'b0;

  // Slave register models: ack one cycle after their sel, unless muted.
  logic [1:0]  muteSlave = 2'b00;
  logic [1:0]  forceAck = 2'b00;
  logic [1:0]  ackReg;
  logic [31:0] rdReg [2];
  logic [31:0] slaveMem [2][16];

  initial begin
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 16; w++)
        slaveMem[s][w] = '0;
  end

  always @(posedge tb_cmd_clk or negedge tb_cmd_srst) begin
    if (!tb_cmd_srst) begin
      ackReg   <= '0;
      rdReg[0] <= '0;
      rdReg[1] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        ackReg[k] <= o_cmd_sel[k] & ~muteSlave[k];
        if (o_cmd_sel[k]) begin
          if (o_cmd_rd_wr_n) rdReg[k] <= slaveMem[k][o_cmd_addr[5:2]];
          else               slaveMem[k][o_cmd_addr[5:2]] <= o_cmd_wdata;
        end
      end
    end
  end

  assign i_cmd_ack   = ackReg | forceAck;
  assign i_cmd_rdata = {rdReg[1], rdReg[0]};

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every slave sel and every host ack is matched against the scoreboard.
  always @(negedge tb_cmd_clk) begin
    if (tb_cmd_srst) begin
      if (o_cmd_sel != 2'b00) begin
        if (cmdQ.size() == 0) begin
          checkValue("unexpected cmd_sel", 64'(o_cmd_sel), 64'(0));
        end else begin
          monCmd = cmdQ.pop_front();
          checkValue("cmd_sel", 64'(o_cmd_sel), 64'(monCmd.sel));
          checkValue("cmd_rd_wr_n", 64'(o_cmd_rd_wr_n), 64'(monCmd.rdWrN));
          checkValue("cmd_addr", 64'(o_cmd_addr), 64'(monCmd.addr));
          checkValue("cmd_wdata", 64'(o_cmd_wdata), 64'(monCmd.wdata));
        end
      end
      if (o_host_ack) begin
        hostAckCount++;
        if (ackQ.size() == 0) begin
          checkValue("unexpected host_ack", 64'(o_host_ack), 64'(0));
        end else begin
          monAck = ackQ.pop_front();
          checkValue("host_rdata", 64'(o_host_rdata), 64'(monAck.rdata));
          checkValue("cmd_err", 64'(o_cmd_err), 64'(monAck.err));
        end
      end
    end
  end

  task automatic pulseHostSel(input logic rdWrN, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge tb_cmd_clk);
    i_host_sel       = 1'b1;
    i_host_rd_wr_n   = rdWrN;
    i_host_byte_addr = addr;
    i_host_wdata     = wdata;
    @(negedge tb_cmd_clk);
    i_host_sel       = 1'b0;
  endtask

  // Returns at the first negedge after the host sel edge, when the slave sel is visible.
  task automatic applyStimulus(input vec_t v);
    cmdQ.push_back(cmd_t'{v.expSel, v.rdWrN, v.expCmdAddr, v.wdata});
    ackQ.push_back(ack_t'{v.expRdata, errExpected});
    pulseHostSel(v.rdWrN, v.addr, v.wdata);
  endtask

  task automatic checkOutput(input string name, input int budget, input int expCycles);
    int cycles = 0;
    bit seen = 1'b0;
    while (!seen && cycles < budget) begin
      @(negedge tb_cmd_clk);
      cycles++;
      if (o_host_ack) seen = 1'b1;
    end
    checkValue({name, " ack seen"}, 64'(seen), 64'(1));
    if (seen && expCycles > 0) checkValue({name, " latency"}, 64'(cycles), 64'(expCycles));
    repeat (3) @(negedge tb_cmd_clk);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0000, 32'h1234_5678, 2'b01, 31'h0, 32'h0000_0000};
    vecs[1] = '{1'b0, 32'h8000_0000, 32'hABCD_ABCD, 2'b10, 31'h0, 32'h0000_0000};
    vecs[2] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 2'b01, 31'h0, 32'h1234_5678};
    vecs[3] = '{1'b1, 32'h8000_0000, 32'h0000_0000, 2'b10, 31'h0, 32'hABCD_ABCD};
    vecs[4] = '{1'b0, 32'h0000_0008, 32'h0BAD_F00D, 2'b01, 31'h8, 32'hABCD_ABCD};
    vecs[5] = '{1'b1, 32'h0000_0008, 32'h0000_0000, 2'b01, 31'h8, 32'h0BAD_F00D};
    vecs[6] = '{1'b1, 32'h8000_0000, 32'h0000_0000, 2'b10, 31'h0, 32'hABCD_ABCD};
    vecs[7] = '{1'b0, 32'h8000_0004, 32'hCAFE_F00D, 2'b10, 31'h4, 32'hABCD_ABCD};
    vecs[8] = '{1'b1, 32'h8000_0004, 32'h0000_0000, 2'b10, 31'h4, 32'hCAFE_F00D};

    repeat (3) @(negedge tb_cmd_clk);
    checkValue("reset host_ack", 64'(o_host_ack), 64'(0));
    checkValue("reset host_rdata", 64'(o_host_rdata), 64'(0));
    checkValue("reset cmd_sel", 64'(o_cmd_sel), 64'(0));
    checkValue("reset cmd_addr", 64'(o_cmd_addr), 64'(0));
    checkValue("reset cmd_err", 64'(o_cmd_err), 64'(0));
    tb_cmd_srst = 1'b1;
    repeat (2) @(negedge tb_cmd_clk);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), 20, 2);
    end

    // Foreign ack and a second host sel during WAIT must not complete or issue anything.
    muteSlave = 2'b01;
    ackBefore = hostAckCount;
    applyStimulus('{1'b1, 32'h0000_0000, 32'h0, 2'b01, 31'h0, 32'h1234_5678});
    @(negedge tb_cmd_clk);
    forceAck         = 2'b10;
    i_host_sel       = 1'b1;
    i_host_rd_wr_n   = 1'b0;
    i_host_byte_addr = 32'h8000_0000;
    i_host_wdata     = 32'h1111_1111;
    @(negedge tb_cmd_clk);
    forceAck   = 2'b00;
    i_host_sel = 1'b0;
    repeat (4) @(negedge tb_cmd_clk);
    checkValue("no completion on foreign ack", 64'(hostAckCount), 64'(ackBefore));
    forceAck = 2'b01;
    @(negedge tb_cmd_clk);
    forceAck = 2'b00;
    checkValue("completion on own ack", 64'(o_host_ack), 64'(1));
    repeat (3) @(negedge tb_cmd_clk);
    checkValue("single host ack", 64'(hostAckCount), 64'(ackBefore + 1));

    // Ack in the same cycle as the slave sel completes the transaction from REQ.
    ackBefore = hostAckCount;
    applyStimulus('{1'b0, 32'h0000_0000, 32'h1234_5678, 2'b01, 31'h0, 32'h1234_5678});
    forceAck = 2'b01;
    @(negedge tb_cmd_clk);
    forceAck = 2'b00;
    checkValue("ack during REQ", 64'(o_host_ack), 64'(1));
    repeat (3) @(negedge tb_cmd_clk);
    checkValue("ack during REQ count", 64'(hostAckCount), 64'(ackBefore + 1));

    // Reset while waiting aborts the transaction and clears every output at once.
    muteSlave = 2'b10;
    ackBefore = hostAckCount;
    applyStimulus('{1'b1, 32'h8000_0004, 32'h5555_5555, 2'b10, 31'h4, 32'hCAFE_F00D});
    repeat (2) @(negedge tb_cmd_clk);
    tb_cmd_srst = 1'b0;
    #1;
    checkValue("abort host_ack", 64'(o_host_ack), 64'(0));
    checkValue("abort host_rdata", 64'(o_host_rdata), 64'(0));
    checkValue("abort cmd_sel", 64'(o_cmd_sel), 64'(0));
    checkValue("abort cmd_rd_wr_n", 64'(o_cmd_rd_wr_n), 64'(0));
    checkValue("abort cmd_addr", 64'(o_cmd_addr), 64'(0));
    checkValue("abort cmd_wdata", 64'(o_cmd_wdata), 64'(0));
    checkValue("abort cmd_err", 64'(o_cmd_err), 64'(0));
    ackQ.delete();
    cmdQ.delete();
    repeat (2) @(negedge tb_cmd_clk);
    tb_cmd_srst = 1'b1;
    muteSlave   = 2'b00;
    repeat (4) @(negedge tb_cmd_clk);
    checkValue("no ack after abort", 64'(hostAckCount), 64'(ackBefore));

    applyStimulus('{1'b0, 32'h0000_0004, 32'h600D_CAFE, 2'b01, 31'h4, 32'h0000_0000});
    checkOutput("post-reset write", 20, 2);
    applyStimulus('{1'b1, 32'h0000_0004, 32'h0, 2'b01, 31'h4, 32'h600D_CAFE});
    checkOutput("post-reset read", 20, 2);

`ifdef CMD_MASTER_TIMEOUT_EN
    muteSlave   = 2'b10;
    errExpected = 1'b1;
    applyStimulus('{1'b1, 32'h8000_0000, 32'h0, 2'b10, 31'h0, 32'hDEAD_BEEF});
    checkOutput("timeout", 400, 257);
    checkValue("err sticky", 64'(o_cmd_err), 64'(1));
    muteSlave = 2'b00;
`else
    checkValue("err tied low", 64'(o_cmd_err), 64'(0));
`endif

    checkValue("cmd queue drained", 64'(cmdQ.size()), 64'(0));
    checkValue("ack queue drained", 64'(ackQ.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cmd_bus_master.md
Name: cmd_bus_master

Overview:
- Single-outstanding command-bus master that bridges a simple host register port onto 2**HOST_ADDR_BITS_FOR_SEL point-to-point slave command channels.
- Decodes the upper host address bits to pick one slave, forwards the transaction, waits for that slave's ack, then returns ack and read data to the host.
- Sits between a host/CPU bridge and per-block register slaves.

Parameters:
- HOST_ADDR_BITS, 32, host byte-address width.
- HOST_ADDR_BITS_FOR_SEL, 1, MSBs used as slave index; NUM_SLAVES = 2**HOST_ADDR_BITS_FOR_SEL.
- HOST_DATA_BITS, 32, data width on host and slave channels.
- TIMEOUT_CYCLES, 256, slave-ack timeout. Used only with CMD_MASTER_TIMEOUT_EN.

Ports:
- tb_cmd_clk  in  1  clock; all logic on rising edge.
- tb_cmd_srst  in  1  reset, asynchronous, active-low.
- i_host_sel  in  1  one-cycle request strobe.
- i_host_rd_wr_n  in  1  1 = read, 0 = write.
- i_host_byte_addr  in  HOST_ADDR_BITS  byte address; [MSB -: SEL] selects the slave.
- i_host_wdata  in  HOST_DATA_BITS  write data.
- o_host_ack  out  1  one-cycle completion pulse.
- o_host_rdata  out  HOST_DATA_BITS  read data; valid with ack, held until next ack.
- o_cmd_sel  out  NUM_SLAVES  per-slave one-hot request strobe.
- o_cmd_rd_wr_n  out  1  shared direction.
- o_cmd_addr  out  HOST_ADDR_BITS-HOST_ADDR_BITS_FOR_SEL  shared slave address = host address with the select bits stripped.
- o_cmd_wdata  out  HOST_DATA_BITS  shared write data.
- i_cmd_ack  in  NUM_SLAVES  per-slave ack pulse.
- i_cmd_rdata  in  NUM_SLAVES*HOST_DATA_BITS  per-slave read data, slave k at slice k.
- o_cmd_err  out  1  timeout sticky flag; tied 0 without the macro.

Behaviour:
- Reset state: FSM = IDLE. All outputs = 0: o_host_ack, o_host_rdata, o_cmd_sel, o_cmd_rd_wr_n, o_cmd_addr, o_cmd_wdata, o_cmd_err. Latched slave index = 0.
- Reset asserted mid-transaction aborts it. No host ack is issued.
- FSM states:
  - IDLE: on i_host_sel=1, register rd_wr_n, address split, wdata and slave index; go to REQ.
  - REQ: drive o_cmd_sel[idx]=1 for exactly one cycle, with rd_wr_n/addr/wdata valid; go to WAIT.
  - WAIT: wait for i_cmd_ack[idx]. Acks from other slaves are ignored. On ack, capture i_cmd_rdata[idx] into o_host_rdata (reads only; writes leave it unchanged) and go to DONE.
  - DONE: o_host_ack=1 for one cycle; return to IDLE.
- Shared cmd outputs hold their value from REQ until the next request.
- Latency: host sel at edge N gives slave sel at N+1. A slave ack at edge M gives host ack at M+1.
- i_host_sel while not in IDLE is ignored and not queued. i_host_sel in the same cycle that DONE is driven is also ignored.
- A slave ack arriving in the same cycle as its sel, while in REQ, is accepted as the completion.
- Only one transaction is ever outstanding.

Optional Feature:
- Macro: CMD_MASTER_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT. When it reaches TIMEOUT_CYCLES without the selected ack, go to DONE.
  - o_host_rdata = 32'hDEAD_BEEF, truncated or zero-extended to HOST_DATA_BITS.
  - o_cmd_err sets and stays set until reset.
- Undefined: WAIT blocks indefinitely and o_cmd_err is constant 0.

Test Plan:
- Bench uses NUM_SLAVES=2 register-slave models that ack one cycle after sel.
- Write 0x12345678 to 0x00000000 -> o_cmd_sel=2'b01, o_cmd_addr=0, rd_wr_n=0; host ack pulses once, 1 cycle after slave ack.
- Write 0xABCDABCD to 0x80000000 -> o_cmd_sel=2'b10, o_cmd_addr=0, wdata=0xABCDABCD; single ack pulse.
- Read 0x00000000 -> o_host_rdata=0x12345678 with ack. Read 0x80000000 -> 0xABCDABCD, showing no slave aliasing.
- Second i_host_sel asserted during WAIT -> no extra slave sel and exactly one host ack. Spurious i_cmd_ack[1] while waiting on slave 0 -> no completion.
- Assert tb_cmd_srst=0 during WAIT -> all outputs 0 immediately. After release, a new write completes normally.
- With CMD_MASTER_TIMEOUT_EN and a slave that never acks -> ack after 256 WAIT cycles, rdata=0xDEADBEEF, o_cmd_err=1.
